// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame constants and parity helpers.
package uart_pkg;

  // Receiver state encoding
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_CLEANUP
  } rx_state_t;

  // 10 MHz system clock / 115200 baud
  localparam int CLK_CY_PER_BIT_DEFAULT = 87;

  // Frame shape: start, DATA_BITS data bits LSB-first, parity, stop
  localparam int DATA_BITS = 8;

  // Parity-mode selector values
  localparam bit PARITY_MODE_EVEN = 1'b0;
  localparam bit PARITY_MODE_ODD  = 1'b1;

  // Parity bit a transmitter sends for this data (even: ^data, odd: ~^data)
  function automatic logic parity_of(input logic [DATA_BITS-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_rx_parity_if.sv
// Byte-level side of the UART receiver: received byte, valid strobe, activity and error flags.
interface uart_rx_parity_if;
  logic       rx_active;
  logic       rx_dv;
  logic [7:0] rx_byte;
  logic       parity_err;
  logic       frame_err;

  modport master (
    output rx_active,
    output rx_dv,
    output rx_byte,
    output parity_err,
    output frame_err
  );

  modport slave (
    input rx_active,
    input rx_dv,
    input rx_byte,
    input parity_err,
    input frame_err
  );
endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for a single asynchronous input; reset value is a parameter so
// idle-high lines do not show a spurious edge when reset is released.
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_sync
);

  logic meta;

  // Two back-to-back flops to let metastability settle before anything uses the value
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      meta   <= RESET_VAL;
      o_sync <= RESET_VAL;
    end else begin
      meta   <= i_async;
      o_sync <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_parity.sv
// UART receiver: start, 8 data bits LSB-first, parity, stop. Delivers each byte with a
// one-cycle valid strobe plus parity and framing error flags; bytes are not buffered.
module uart_rx_parity
  import uart_pkg::*;
#(
  parameter int CLK_CY_PER_BIT = CLK_CY_PER_BIT_DEFAULT,
  parameter bit PARITY_ODD     = PARITY_MODE_EVEN
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_Rx_Serial,
  uart_rx_parity_if.master  rx_if
);

  localparam int CNT_W = $clog2(CLK_CY_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'((CLK_CY_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLK_CY_PER_BIT - 1);

  logic rx_s;
  logic rx_prev;

  rx_state_t            state, state_next;
  logic [CNT_W-1:0]     clk_cnt, clk_cnt_next;
  logic [2:0]           bit_idx, bit_idx_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic                 par_err_q, par_err_next;
  logic                 active_q, active_next;
  logic                 dv_q, dv_next;
  logic [DATA_BITS-1:0] byte_q, byte_next;
  logic                 parity_err_q, parity_err_next;
  logic                 frame_err_q, frame_err_next;

  uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_async (i_Rx_Serial),
    .o_sync  (rx_s)
  );

  // State, counters, shift register and registered outputs
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= ST_IDLE;
      clk_cnt      <= '0;
      bit_idx      <= '0;
      shift_reg    <= '0;
      par_err_q    <= 1'b0;
      rx_prev      <= 1'b1;
      active_q     <= 1'b0;
      dv_q         <= 1'b0;
      byte_q       <= '0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state        <= state_next;
      clk_cnt      <= clk_cnt_next;
      bit_idx      <= bit_idx_next;
      shift_reg    <= shift_next;
      par_err_q    <= par_err_next;
      rx_prev      <= rx_s;
      active_q     <= active_next;
      dv_q         <= dv_next;
      byte_q       <= byte_next;
      parity_err_q <= parity_err_next;
      frame_err_q  <= frame_err_next;
    end
  end

  // Frame sequencing: start edge, mid-bit sampling of each field, one-cycle result strobe
  always_comb begin
    state_next      = state;
    clk_cnt_next    = clk_cnt;
    bit_idx_next    = bit_idx;
    shift_next      = shift_reg;
    par_err_next    = par_err_q;
    active_next     = active_q;
    dv_next         = 1'b0;
    byte_next       = byte_q;
    parity_err_next = parity_err_q;
    frame_err_next  = frame_err_q;

    case (state)
      ST_IDLE: begin
        clk_cnt_next = '0;
        bit_idx_next = '0;
        active_next  = 1'b0;
        // Only a high-to-low transition starts a frame, so a held-low break is ignored
        if (rx_prev && !rx_s) begin
          state_next  = ST_START;
          active_next = 1'b1;
        end
      end

      ST_START: begin
        if (clk_cnt == HALF_CNT) begin
          clk_cnt_next = '0;
          if (!rx_s) begin
            state_next = ST_DATA;
          end else begin
            state_next  = ST_IDLE;
            active_next = 1'b0;
          end
        end else begin
          clk_cnt_next = clk_cnt + CNT_W'(1);
        end
      end

      ST_DATA: begin
        if (clk_cnt == LAST_CNT) begin
          clk_cnt_next        = '0;
          shift_next[bit_idx] = rx_s;
          bit_idx_next        = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
            state_next = ST_PARITY;
          end
        end else begin
          clk_cnt_next = clk_cnt + CNT_W'(1);
        end
      end

      ST_PARITY: begin
        if (clk_cnt == LAST_CNT) begin
          clk_cnt_next = '0;
          par_err_next = rx_s ^ parity_of(shift_reg, PARITY_ODD);
          state_next   = ST_STOP;
        end else begin
          clk_cnt_next = clk_cnt + CNT_W'(1);
        end
      end

      ST_STOP: begin
        // Results are registered here so they appear together with the strobe in CLEANUP
        if (clk_cnt == LAST_CNT) begin
          clk_cnt_next    = '0;
          dv_next         = 1'b1;
          byte_next       = shift_reg;
          parity_err_next = par_err_q;
          frame_err_next  = ~rx_s;
          active_next     = 1'b0;
          state_next      = ST_CLEANUP;
        end else begin
          clk_cnt_next = clk_cnt + CNT_W'(1);
        end
      end

      ST_CLEANUP: begin
        state_next = ST_IDLE;
      end

      default: begin
        state_next  = ST_IDLE;
        active_next = 1'b0;
      end
    endcase
  end

  assign rx_if.rx_active  = active_q;
  assign rx_if.rx_dv      = dv_q;
  assign rx_if.rx_byte    = byte_q;
  assign rx_if.parity_err = parity_err_q;
  assign rx_if.frame_err  = frame_err_q;

endmodule
